// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default parameters and
// the serial bit time used by the transmitter at the 50 MHz system clock.
package uart_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEFAULT     = 32'd4;
    localparam int STALL_LIMIT_DEFAULT = 32'd1024;

    localparam int CLK_PERIOD_NS   = 32'd20;
    localparam int BIT_TIME_NS     = 32'd102000;
    localparam int BIT_TIME_CYCLES = BIT_TIME_NS / CLK_PERIOD_NS;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr_i, wrapping
// modulo N. Produces a one-hot winner and a flag that any request exists.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          valid_o
);

    logic [PW-1:0] idx_s;

    // Walk the requests starting at the pointer; the first hit masks the rest.
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s        = PW'((int'(ptr_i) + k) % N);
            win_o[idx_s] = req_i[idx_s] & ~valid_o;
            valid_o      = valid_o | req_i[idx_s];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams. A requester owns
// the transmitter for a whole message (until req_last) and loses it early
// only if it stops offering bytes for STALL_LIMIT cycles. The byte path is a
// combinational pass-through so the owner sees no extra latency.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEFAULT,
    parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic                 clk50m,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 stall_abort
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PW-1:0]      gidx_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [SW-1:0]      stall_cnt_q;
    logic               stall_abort_q;

    logic [7:0]         req_bytes_s [NUM_REQ];
    logic [NUM_REQ-1:0] pick_win_s;
    logic               pick_valid_s;
    logic [PW-1:0]      pick_idx_s;
    logic [PW-1:0]      next_ptr_s;
    logic               g_valid_s;
    logic               g_last_s;
    logic               fire_s;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_bytes_s[i] = req_data[8*i +: 8];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .win_o   (pick_win_s),
        .valid_o (pick_valid_s)
    );

    // Encode the one-hot winner as an index for the data/valid muxes.
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_idx_s = pick_idx_s | (PW'(i) & {PW{pick_win_s[i]}});
        end
    end

    // Pointer to the requester after the current owner, wrapping to zero.
    always_comb begin
        if (gidx_q == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_q + PW'(1);
        end
    end

    // Owner pass-through: valid/data to the UART, tx_ready back to the owner.
    always_comb begin
        g_valid_s = req_valid[gidx_q];
        g_last_s  = req_last[gidx_q];
        if (state_q == ST_XFER) begin
            tx_valid  = g_valid_s;
            tx_data   = req_bytes_s[gidx_q];
            req_ready = grant_q & {NUM_REQ{tx_ready}};
        end else begin
            tx_valid  = 1'b0;
            tx_data   = 8'h00;
            req_ready = '0;
        end
        fire_s = tx_valid & tx_ready;
    end

    assign grant       = grant_q;
    assign stall_abort = stall_abort_q;

    // Arbiter FSM: grant in IDLE, hold through the message, release on last or stall.
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            stall_cnt_q   <= '0;
            stall_abort_q <= 1'b0;
        end else begin
            stall_abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_q     <= ST_XFER;
                        grant_q     <= pick_win_s;
                        gidx_q      <= pick_idx_s;
                        stall_cnt_q <= '0;
                    end
                end
                ST_XFER: begin
                    if (fire_s) begin
                        stall_cnt_q <= '0;
                        if (g_last_s) begin
                            state_q  <= ST_IDLE;
                            grant_q  <= '0;
                            rr_ptr_q <= next_ptr_s;
                        end
                    end else if (!g_valid_s) begin
                        if (stall_cnt_q == STALL_MAX) begin
                            state_q       <= ST_IDLE;
                            grant_q       <= '0;
                            rr_ptr_q      <= next_ptr_s;
                            stall_cnt_q   <= '0;
                            stall_abort_q <= 1'b1;
                        end else begin
                            stall_cnt_q <= stall_cnt_q + SW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for stall timeout, long back-pressure and
// mid-message reset.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int STALL = 1024;

    logic        clk50m = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        stall_abort;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .STALL_LIMIT (STALL)
    ) dut (
        .clk50m      (clk50m),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .stall_abort (stall_abort)
    );

    always #10 clk50m = ~clk50m;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        txr;
        logic        e_tv;
        logic [7:0]  e_td;
        logic [3:0]  e_rdy;
        logic [3:0]  e_gnt;
        logic        e_ab;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic etv, input logic [7:0] etd,
                         input logic [3:0] erdy, input logic [3:0] egnt, input logic eab);
        n_cmp++;
        if (tx_valid !== etv || tx_data !== etd || req_ready !== erdy ||
            grant !== egnt || stall_abort !== eab) begin
            n_err++;
            $display("FAIL %s: got tv=%b td=%h rdy=%b gnt=%b ab=%b, expected tv=%b td=%h rdy=%b gnt=%b ab=%b",
                     name, tx_valid, tx_data, req_ready, grant, stall_abort,
                     etv, etd, erdy, egnt, eab);
        end
    endtask

    // Apply inputs just after an edge, check mid-cycle, advance to the next edge.
    task automatic cycle(input string name, input logic [3:0] v, input logic [31:0] d,
                         input logic [3:0] l, input logic r, input logic etv,
                         input logic [7:0] etd, input logic [3:0] erdy,
                         input logic [3:0] egnt, input logic eab);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
        #4;
        check(name, etv, etd, erdy, egnt, eab);
        @(posedge clk50m);
        #1;
    endtask

    initial begin
        // Table: valid, data{d3,d2,d1,d0}, last, tx_ready | tv, td, ready, grant, abort
        vecs[0]  = '{4'b0101, 32'h00C0_00A0, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0101, 32'h00C0_00A0, 4'b0000, 1'b0, 1'b1, 8'hA0, 4'b0000, 4'b0001, 1'b0};
        vecs[2]  = '{4'b0101, 32'h00C0_00A0, 4'b0000, 1'b1, 1'b1, 8'hA0, 4'b0001, 4'b0001, 1'b0};
        vecs[3]  = '{4'b0101, 32'h00C0_00A1, 4'b0001, 1'b1, 1'b1, 8'hA1, 4'b0001, 4'b0001, 1'b0};
        vecs[4]  = '{4'b0100, 32'h00C0_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[5]  = '{4'b0100, 32'h00C0_0000, 4'b0000, 1'b1, 1'b1, 8'hC0, 4'b0100, 4'b0100, 1'b0};
        vecs[6]  = '{4'b0101, 32'h00C1_00A2, 4'b0100, 1'b1, 1'b1, 8'hC1, 4'b0100, 4'b0100, 1'b0};
        vecs[7]  = '{4'b0001, 32'h0000_0048, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[8]  = '{4'b0001, 32'h0000_0048, 4'b0000, 1'b1, 1'b1, 8'h48, 4'b0001, 4'b0001, 1'b0};
        vecs[9]  = '{4'b0001, 32'h0000_0049, 4'b0000, 1'b1, 1'b1, 8'h49, 4'b0001, 4'b0001, 1'b0};
        vecs[10] = '{4'b0001, 32'h0000_0020, 4'b0001, 1'b1, 1'b1, 8'h20, 4'b0001, 4'b0001, 1'b0};
        vecs[11] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[12] = '{4'b1000, 32'h3300_0000, 4'b1000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[13] = '{4'b1000, 32'h3300_0000, 4'b1000, 1'b1, 1'b1, 8'h33, 4'b1000, 4'b1000, 1'b0};
        vecs[14] = '{4'b1001, 32'h3400_0050, 4'b1001, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[15] = '{4'b1001, 32'h3400_0050, 4'b1001, 1'b1, 1'b1, 8'h50, 4'b0001, 4'b0001, 1'b0};
        vecs[16] = '{4'b1001, 32'h3400_0050, 4'b1001, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};
        vecs[17] = '{4'b1001, 32'h3400_0050, 4'b1001, 1'b1, 1'b1, 8'h34, 4'b1000, 4'b1000, 1'b0};
        vecs[18] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0};

        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0000_0000;
        req_last  = 4'b0000;
        tx_ready  = 1'b1;
        #5;
        check("reset_state", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk50m);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].data, vecs[i].last,
                  vecs[i].txr, vecs[i].e_tv, vecs[i].e_td, vecs[i].e_rdy,
                  vecs[i].e_gnt, vecs[i].e_ab);
        end

        // Stall timeout: requester 1 sends one byte then goes quiet, requester 2 waits.
        cycle("stall_idle", 4'b0010, 32'h0000_4100, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        cycle("stall_byte", 4'b0010, 32'h0000_4100, 4'b0000, 1'b1, 1'b1, 8'h41, 4'b0010, 4'b0010, 1'b0);
        for (int k = 0; k < STALL; k++) begin
            cycle("stall_hold", 4'b0100, 32'h0055_0000, 4'b0000, 1'b1,
                  1'b0, 8'h00, 4'b0010, 4'b0010, 1'b0);
        end
        cycle("stall_abort", 4'b0100, 32'h0055_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b1);
        cycle("stall_next", 4'b0100, 32'h0055_0000, 4'b0100, 1'b1, 1'b1, 8'h55, 4'b0100, 4'b0100, 1'b0);
        cycle("stall_done", 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);

        // Long back-pressure on requester 3 must never count as a stall.
        cycle("bp_idle", 4'b1000, 32'h7700_0000, 4'b1000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < 5000; k++) begin
            cycle("bp_hold", 4'b1000, 32'h7700_0000, 4'b1000, 1'b0,
                  1'b1, 8'h77, 4'b0000, 4'b1000, 1'b0);
        end
        cycle("bp_release", 4'b1000, 32'h7700_0000, 4'b1000, 1'b1, 1'b1, 8'h77, 4'b1000, 4'b1000, 1'b0);
        cycle("bp_done", 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);

        // Move rr_ptr to 1, then reset in the middle of requester 1's message.
        cycle("rst_pre_idle", 4'b0001, 32'h0000_0011, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        cycle("rst_pre_byte", 4'b0001, 32'h0000_0011, 4'b0001, 1'b1, 1'b1, 8'h11, 4'b0001, 4'b0001, 1'b0);
        cycle("rst_msg_idle", 4'b0010, 32'h0000_2100, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        cycle("rst_msg_b1", 4'b0010, 32'h0000_2100, 4'b0000, 1'b1, 1'b1, 8'h21, 4'b0010, 4'b0010, 1'b0);
        req_data = 32'h0000_2200;
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk50m);
        #1;
        check("rst_held", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        cycle("rst_after_idle", 4'b0011, 32'h0000_3130, 4'b0011, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        cycle("rst_after_ptr0", 4'b0011, 32'h0000_3130, 4'b0011, 1'b1, 1'b1, 8'h30, 4'b0001, 4'b0001, 1'b0);
        cycle("rst_after_done", 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
